// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - requester handshake bundle for one alu_sched port
interface alu_sched_if;
  logic       req;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       grant;
  logic       done;

  modport master (output req, op, a, b, input grant, done);
  modport slave  (input req, op, a, b, output grant, done);
endinterface

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin ALU sharing scheduler with wait states and flag register
// Optional ALU_SCHED_PERF_EN adds saturating per-port completion counters.
module alu_sched #(
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_LAT     = 4,
  parameter logic [7:0]  DIV0_RESULT = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_sched_if.slave  port0_if,
  alu_sched_if.slave  port1_if,
  output logic [7:0]  result_o,
  output logic [3:0]  flags_o,
  output logic        div_err_o,
  input  logic        flag_load_i,
  input  logic [3:0]  flag_in_i,
  output logic [7:0]  alu_x_o,
  output logic [7:0]  alu_y_o,
  output logic [2:0]  alu_func_o,
  input  logic [7:0]  alu_z_i,
  input  logic        alu_carry_i
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [15:0] ops0_o,
  output logic [15:0] ops1_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        div0_q, div0_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [2:0]  func_q, func_d;
  logic [7:0]  result_q, result_d;
  logic [3:0]  flags_q, flags_d;

  logic        win, any_req, arb_ok, ovf, cy;
  logic [2:0]  w_op;
  logic [7:0]  w_a, w_b;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    div0_d   = div0_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    func_d   = func_q;
    result_d = result_q;
    flags_d  = flags_q;

    // On contention the port that was not served last takes the ALU.
    any_req = port0_if.req | port1_if.req;
    win     = (port0_if.req & port1_if.req) ? ~last_q : port1_if.req;
    w_op    = win ? port1_if.op : port0_if.op;
    w_a     = win ? port1_if.a  : port0_if.a;
    w_b     = win ? port1_if.b  : port0_if.b;
    arb_ok  = (state_q == S_DONE) || (state_q == S_IDLE && !flag_load_i);

    cy = (func_q == 3'b000 || func_q == 3'b001 || func_q == 3'b010) ? alu_carry_i : 1'b0;
    unique case (func_q)
      3'b000:  ovf = (x_q[7] == y_q[7]) && (alu_z_i[7] != x_q[7]);
      3'b001:  ovf = (x_q[7] != y_q[7]) && (alu_z_i[7] != x_q[7]);
      3'b010:  ovf = alu_carry_i;
      default: ovf = 1'b0;
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (flag_load_i) flags_d = flag_in_i;
      end
      S_EXEC: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_DONE;
          if (div0_q) begin
            result_d = DIV0_RESULT;
            flags_d  = 4'b0110;
          end else begin
            result_d = alu_z_i;
            flags_d  = {alu_z_i == 8'd0, alu_z_i[7], ovf, cy};
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // DONE re-arbitrates in the same cycle so back-to-back ops need no gap.
    if (arb_ok && any_req) begin
      state_d = S_EXEC;
      owner_d = win;
      last_d  = win;
      func_d  = w_op;
      x_d     = w_a;
      y_d     = w_b;
      div0_d  = (w_op == 3'b011) && (w_b == 8'd0);
      if (w_op == 3'b010)                      cnt_d = 8'(MUL_LAT);
      else if (w_op == 3'b011 && w_b != 8'd0)  cnt_d = 8'(DIV_LAT);
      else                                     cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      div0_q   <= 1'b0;
      cnt_q    <= 8'd0;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      func_q   <= 3'd0;
      result_q <= 8'd0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      div0_q   <= div0_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      func_q   <= func_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign port0_if.grant = (state_q != S_IDLE) && !owner_q;
  assign port1_if.grant = (state_q != S_IDLE) &&  owner_q;
  assign port0_if.done  = (state_q == S_DONE) && !owner_q;
  assign port1_if.done  = (state_q == S_DONE) &&  owner_q;
  assign div_err_o      = (state_q == S_DONE) &&  div0_q;
  assign result_o       = result_q;
  assign flags_o        = flags_q;
  assign alu_x_o        = x_q;
  assign alu_y_o        = y_q;
  assign alu_func_o     = func_q;

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] ops0_q, ops1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ops0_q <= 16'd0;
      ops1_q <= 16'd0;
    end else begin
      if (port0_if.done && ops0_q != 16'hFFFF) ops0_q <= ops0_q + 16'd1;
      if (port1_if.done && ops1_q != 16'hFFFF) ops1_q <= ops1_q + 16'd1;
    end
  end

  assign ops0_o = ops0_q;
  assign ops1_o = ops1_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - scoreboard bench for alu_sched with a behavioural ALU
module tb_alu_sched;
  logic       clk;
  logic       rst;
  logic [7:0] result;
  logic [3:0] flags;
  logic       div_err;
  logic       flag_load;
  logic [3:0] flag_in;
  logic [7:0] alu_x, alu_y, alu_z;
  logic [2:0] alu_func;
  logic       alu_carry;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0] ops0, ops1;
`endif

  alu_sched_if p0 ();
  alu_sched_if p1 ();

  alu_sched dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .port0_if    (p0),
    .port1_if    (p1),
    .result_o    (result),
    .flags_o     (flags),
    .div_err_o   (div_err),
    .flag_load_i (flag_load),
    .flag_in_i   (flag_in),
    .alu_x_o     (alu_x),
    .alu_y_o     (alu_y),
    .alu_func_o  (alu_func),
    .alu_z_i     (alu_z),
    .alu_carry_i (alu_carry)
`ifdef ALU_SCHED_PERF_EN
    ,
    .ops0_o      (ops0),
    .ops1_o      (ops1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    case (op)
      3'b000:  alu_fn = {1'b0, x} + {1'b0, y};
      3'b001:  alu_fn = {(x < y), x - y};
      3'b010:  begin p = x * y; alu_fn = {|p[15:8], p[7:0]}; end
      3'b011:  alu_fn = (y == 8'd0) ? 9'h0 : {1'b0, x / y};
      3'b100:  alu_fn = {1'b0, x & y};
      3'b101:  alu_fn = {1'b0, x | y};
      3'b110:  alu_fn = {1'b0, ~x};
      default: alu_fn = {1'b0, x ^ y};
    endcase
  endfunction

  always_comb {alu_carry, alu_z} = alu_fn(alu_func, alu_x, alu_y);

  typedef struct packed {
    logic       port;
    logic [7:0] r;
    logic [3:0] f;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t model(input logic port, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] cz;
    logic       o;
    exp_t       e;
    cz = alu_fn(op, a, b);
    e.port = port;
    e.err  = 1'b0;
    e.r    = cz[7:0];
    case (op)
      3'b000:  o = (a[7] == b[7]) && (cz[7] != a[7]);
      3'b001:  o = (a[7] != b[7]) && (cz[7] != a[7]);
      3'b010:  o = cz[8];
      default: o = 1'b0;
    endcase
    e.f = {cz[7:0] == 8'd0, cz[7], o, (op <= 3'b010) ? cz[8] : 1'b0};
    if (op == 3'b011 && b == 8'd0) begin
      e.r   = 8'hFF;
      e.f   = 4'b0110;
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic port, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (port) begin p1.req = 1'b1; p1.op = op; p1.a = a; p1.b = b; end
    else      begin p0.req = 1'b1; p0.op = op; p0.a = a; p0.b = b; end
    sb.push_back(model(port, op, a, b));
  endtask

  task automatic wait_done(output bit got, output logic port, output int cyc);
    got  = 1'b0;
    port = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cyc++;
      if (p0.done || p1.done) begin
        got  = 1'b1;
        port = p1.done;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0.req = 1'b0;
    p1.req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({p0.grant, p1.grant, p0.done, p1.done, div_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {p0.grant, p1.grant, p0.done, p1.done, div_err});
    end
    n_tests++;
    if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", result); end
    n_tests++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_tests++;
    if ({alu_x, alu_y, alu_func} !== 19'd0) begin
      n_fail++; $display("FAIL reset_alu_bus: got %h want 0", {alu_x, alu_y, alu_func});
    end
  endtask

  task automatic test_add();
    exp_t e;
    issue(1'b0, 3'b000, 8'h7F, 8'h01);
    step();
    n_tests++;
    if ({p0.grant, p0.done} !== 2'b10) begin n_fail++; $display("FAIL add_cycle1: got %b want 10", {p0.grant, p0.done}); end
    p0.a = 8'h55;
    step();
    e = sb.pop_front();
    n_tests++;
    if ({p0.grant, p0.done, p1.done} !== 3'b110) begin
      n_fail++; $display("FAIL add_done: got %b want 110", {p0.grant, p0.done, p1.done});
    end
    n_tests++;
    if ({result, flags} !== {e.r, e.f} || flags !== 4'b0110) begin
      n_fail++; $display("FAIL add_result: got %h/%b want %h/%b", result, flags, e.r, e.f);
    end
    n_tests++;
    if (alu_x !== 8'h7F) begin n_fail++; $display("FAIL add_latched_x: got %h want 7f", alu_x); end
    p0.req = 1'b0;
    step();
    n_tests++;
    if (p0.grant !== 1'b0) begin n_fail++; $display("FAIL add_release: got %b want 0", p0.grant); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic own;
    do_reset();
    p0.req = 1'b1; p0.op = 3'b100; p0.a = 8'hF0; p0.b = 8'h3C;
    p1.req = 1'b1; p1.op = 3'b100; p1.a = 8'h0F; p1.b = 8'hFF;
    for (int k = 0; k < 4; k++) sb.push_back(model(k[0], 3'b100, k[0] ? 8'h0F : 8'hF0, k[0] ? 8'hFF : 8'h3C));
    for (int c = 1; c <= 8; c++) begin
      step();
      own = ((c - 1) / 2) % 2 == 1;
      n_tests++;
      if ({p0.grant, p1.grant} !== {~own, own} || (p0.done && p1.done)) begin
        n_fail++; $display("FAIL b2b_grant c%0d: got g%b d%b want owner %0d", c, {p0.grant, p1.grant}, {p0.done, p1.done}, own);
      end
      if (c % 2 == 0) begin
        e = sb.pop_front();
        n_tests++;
        if ({p1.done, p0.done} !== {e.port, ~e.port} || result !== e.r || flags !== e.f) begin
          n_fail++; $display("FAIL b2b_done c%0d: got d%b %h/%b want port %0d %h/%b", c, {p0.done, p1.done}, result, flags, e.port, e.r, e.f);
        end
      end
      if (c == 8) begin p0.req = 1'b0; p1.req = 1'b0; end
    end
    step();
    n_tests++;
    if ({p0.grant, p1.grant} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle: got %b want 00", {p0.grant, p1.grant}); end
  endtask

  task automatic test_mul();
    exp_t e;
    bit got;
    logic port;
    int cyc;
    issue(1'b1, 3'b010, 8'h10, 8'h10);
    wait_done(got, port, cyc);
    e = sb.pop_front();
    n_tests++;
    if (!got || port !== 1'b1 || cyc != 4) begin
      n_fail++; $display("FAIL mul_latency: got done=%0d port=%0d cyc=%0d want 1/1/4", got, port, cyc);
    end
    n_tests++;
    if ({result, flags} !== {e.r, e.f} || flags !== 4'b1011) begin
      n_fail++; $display("FAIL mul_result: got %h/%b want %h/%b", result, flags, e.r, e.f);
    end
    p1.op = 3'b000; p1.a = 8'h01; p1.b = 8'h01;
    sb.push_back(model(1'b1, 3'b000, 8'h01, 8'h01));
    wait_done(got, port, cyc);
    e = sb.pop_front();
    p1.req = 1'b0;
    n_tests++;
    if (!got || cyc != 2 || {result, flags} !== {e.r, e.f} || flags !== 4'b0000) begin
      n_fail++; $display("FAIL add_after_mul: got done=%0d cyc=%0d %h/%b want 1/2 %h/%b", got, cyc, result, flags, e.r, e.f);
    end
    step();
  endtask

  task automatic test_div();
    exp_t e;
    bit got;
    logic port;
    int cyc;
    issue(1'b0, 3'b011, 8'h20, 8'h00);
    wait_done(got, port, cyc);
    e = sb.pop_front();
    p0.req = 1'b0;
    n_tests++;
    if (!got || port !== 1'b0 || cyc != 2 || div_err !== e.err || div_err !== 1'b1) begin
      n_fail++; $display("FAIL div0_timing: got done=%0d port=%0d cyc=%0d err=%b want 1/0/2/1", got, port, cyc, div_err);
    end
    n_tests++;
    if ({result, flags} !== {e.r, e.f}) begin
      n_fail++; $display("FAIL div0_result: got %h/%b want %h/%b", result, flags, e.r, e.f);
    end
    step();
    n_tests++;
    if (div_err !== 1'b0) begin n_fail++; $display("FAIL div0_pulse: got %b want 0", div_err); end
    issue(1'b0, 3'b011, 8'h20, 8'h03);
    wait_done(got, port, cyc);
    e = sb.pop_front();
    p0.req = 1'b0;
    n_tests++;
    if (!got || cyc != 6 || div_err !== 1'b0 || {result, flags} !== {e.r, e.f}) begin
      n_fail++; $display("FAIL div_normal: got done=%0d cyc=%0d err=%b %h/%b want 1/6/0 %h/%b", got, cyc, div_err, result, flags, e.r, e.f);
    end
    step();
  endtask

  task automatic test_flag_load();
    exp_t e;
    bit got;
    logic port;
    int cyc;
    flag_load = 1'b1;
    flag_in   = 4'b1001;
    issue(1'b0, 3'b010, 8'h03, 8'h03);
    step();
    n_tests++;
    if (flags !== 4'b1001 || p0.grant !== 1'b0) begin
      n_fail++; $display("FAIL fload_idle: got %b g%b want 1001 g0", flags, p0.grant);
    end
    flag_load = 1'b0;
    step();
    n_tests++;
    if (p0.grant !== 1'b1) begin n_fail++; $display("FAIL fload_delayed_grant: got %b want 1", p0.grant); end
    flag_load = 1'b1;
    flag_in   = 4'b0101;
    step();
    n_tests++;
    if (flags !== 4'b1001) begin n_fail++; $display("FAIL fload_exec_ignored: got %b want 1001", flags); end
    flag_load = 1'b0;
    wait_done(got, port, cyc);
    e = sb.pop_front();
    p0.req = 1'b0;
    n_tests++;
    if (!got || cyc != 2 || {result, flags} !== {e.r, e.f}) begin
      n_fail++; $display("FAIL fload_op: got done=%0d cyc=%0d %h/%b want 1/2 %h/%b", got, cyc, result, flags, e.r, e.f);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int seen;
    flag_load = 1'b1;
    flag_in   = 4'b1111;
    step();
    flag_load = 1'b0;
    n_tests++;
    if (flags !== 4'b1111) begin n_fail++; $display("FAIL abort_preload: got %b want 1111", flags); end
    p0.req = 1'b1; p0.op = 3'b011; p0.a = 8'h20; p0.b = 8'h03;
    step();
    step();
    rst = 1'b1;
    p0.req = 1'b0;
    step();
    n_tests++;
    if ({p0.grant, p0.done, p1.grant, p1.done} !== 4'b0 || flags !== 4'b0000) begin
      n_fail++; $display("FAIL abort_state: got g/d %b flags %b want 0000/0000", {p0.grant, p0.done, p1.grant, p1.done}, flags);
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (p0.done || p1.done) seen++;
    end
    n_tests++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d dones want 0", seen); end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1;
    flag_load = 1'b0;
    flag_in = 4'b0000;
    p0.req = 1'b0; p0.op = 3'b000; p0.a = 8'h00; p0.b = 8'h00;
    p1.req = 1'b0; p1.op = 3'b000; p1.a = 8'h00; p1.b = 8'h00;
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_div();
    test_flag_load();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
